// File: rtl/intersection_arbiter_pkg.sv
// Shared encodings and default timing for the intersection controller family.
// Lamp encoder, status message and arbiter all import this package.
package intersection_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_GREEN  = 2'd1,
      ST_AMBER  = 2'd2,
      ST_ALLRED = 2'd3
   } state_t;

   localparam logic [1:0] DIR_NS = 2'd0;
   localparam logic [1:0] DIR_SN = 2'd1;
   localparam logic [1:0] DIR_EW = 2'd2;
   localparam logic [1:0] DIR_WE = 2'd3;

   localparam int T_MIN_GREEN_DEF = 10;
   localparam int T_MAX_GREEN_DEF = 40;
   localparam int T_GAP_DEF       = 4;
   localparam int T_AMBER_DEF     = 6;
   localparam int T_ALLRED_DEF    = 2;
   localparam int CW_DEF          = 6;

   function automatic logic [3:0] onehot4(input logic [1:0] idx);
      onehot4 = 4'b0001 << idx;
   endfunction

endpackage

// File: rtl/intersection_arbiter_rr_pick4.sv
// Round-robin pick over four pending flags, searching upward from last+1 with wrap.
// Purely combinational; the caller registers the result.
module rr_pick4 (
   input  logic [3:0] pending,
   input  logic [1:0] last,
   output logic [1:0] winner,
   output logic       valid
);

   logic [1:0] start_s;
   logic [7:0] dbl_s;
   logic [3:0] rot_s;
   logic [1:0] off_s;

   // Rotate so that bit 0 of rot_s is the approach right after the last one served.
   assign start_s = last + 2'd1;
   assign dbl_s   = {pending, pending};
   assign rot_s   = dbl_s[{1'b0, start_s} +: 4];

   // Lowest set bit of the rotated vector gives the offset from start_s.
   always_comb begin
      off_s = 2'd0;
      casez (rot_s)
         4'b???1: off_s = 2'd0;
         4'b??10: off_s = 2'd1;
         4'b?100: off_s = 2'd2;
         4'b1000: off_s = 2'd3;
         default: off_s = 2'd0;
      endcase
   end

   assign winner = start_s + off_s;
   assign valid  = |pending;

endmodule

// File: rtl/intersection_arbiter.sv
// Four-approach round-robin intersection arbiter with min/max green, gap-out,
// amber and all-red clearance timing counted in clock ticks.
module intersection_arbiter
   import intersection_arbiter_pkg::*;
#(
   parameter int T_MIN_GREEN = T_MIN_GREEN_DEF,
   parameter int T_MAX_GREEN = T_MAX_GREEN_DEF,
   parameter int T_GAP       = T_GAP_DEF,
   parameter int T_AMBER     = T_AMBER_DEF,
   parameter int T_ALLRED    = T_ALLRED_DEF,
   parameter int CW          = CW_DEF
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [3:0]    req,
   output logic [3:0]    grant,
   output logic [3:0]    amber,
   output logic [1:0]    state,
   output logic [3:0]    pending,
   output logic [CW-1:0] elapsed,
   output logic [1:0]    last
);

   localparam logic [CW-1:0] MIN_M1    = CW'(T_MIN_GREEN - 1);
   localparam logic [CW-1:0] MAX_M1    = CW'(T_MAX_GREEN - 1);
   localparam logic [CW-1:0] GAP_M1    = CW'(T_GAP - 1);
   localparam logic [CW-1:0] AMBER_M1  = CW'(T_AMBER - 1);
   localparam logic [CW-1:0] ALLRED_M1 = CW'(T_ALLRED - 1);
   localparam logic [CW-1:0] EL_SAT    = {CW{1'b1}};
   localparam logic [CW-1:0] ONE       = CW'(1);

   state_t        state_r;
   logic [3:0]    grant_r;
   logic [3:0]    amber_r;
   logic [3:0]    pending_r;
   logic [CW-1:0] elapsed_r;
   logic [CW-1:0] gap_r;
   logic [1:0]    last_r;

   logic [1:0]    winner_s;
   logic          pick_valid_s;
   logic          go_green_s;
   logic          green_exit_s;
   logic          others_pending_s;
   logic [3:0]    clear_mask_s;
   logic [CW-1:0] el_cap_s;
   logic [CW-1:0] elapsed_inc_s;
   logic [CW-1:0] gap_inc_s;

   rr_pick4 u_pick (
      .pending (pending_r),
      .last    (last_r),
      .winner  (winner_s),
      .valid   (pick_valid_s)
   );

   assign others_pending_s = |(pending_r & ~grant_r);
   assign go_green_s = pick_valid_s &&
                       ((state_r == ST_IDLE) ||
                        ((state_r == ST_ALLRED) && (elapsed_r == ALLRED_M1)));
   // Serving an approach wins over a simultaneous new arrival on it.
   assign clear_mask_s = go_green_s ? onehot4(winner_s) : 4'b0000;
   assign green_exit_s = others_pending_s && (elapsed_r >= MIN_M1) &&
                         ((gap_r >= GAP_M1) || (elapsed_r >= MAX_M1));

   assign el_cap_s      = (state_r == ST_GREEN) ? MAX_M1 : EL_SAT;
   assign elapsed_inc_s = (elapsed_r >= el_cap_s) ? elapsed_r : elapsed_r + ONE;
   assign gap_inc_s     = (|(req & grant_r)) ? {CW{1'b0}} :
                          ((gap_r >= GAP_M1) ? gap_r : gap_r + ONE);

   // Phase sequencer, pending register, lamp grants and tick counters.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r   <= ST_IDLE;
         grant_r   <= 4'b0000;
         amber_r   <= 4'b0000;
         pending_r <= 4'b0000;
         elapsed_r <= {CW{1'b0}};
         gap_r     <= {CW{1'b0}};
         last_r    <= DIR_WE;
      end else begin
         pending_r <= (pending_r | (req & ~grant_r)) & ~clear_mask_s;
         case (state_r)
            ST_IDLE: begin
               if (go_green_s) begin
                  state_r   <= ST_GREEN;
                  grant_r   <= onehot4(winner_s);
                  last_r    <= winner_s;
                  gap_r     <= {CW{1'b0}};
                  elapsed_r <= {CW{1'b0}};
               end else begin
                  elapsed_r <= elapsed_inc_s;
               end
            end
            ST_GREEN: begin
               if (green_exit_s) begin
                  state_r   <= ST_AMBER;
                  amber_r   <= grant_r;
                  grant_r   <= 4'b0000;
                  gap_r     <= {CW{1'b0}};
                  elapsed_r <= {CW{1'b0}};
               end else begin
                  gap_r     <= gap_inc_s;
                  elapsed_r <= elapsed_inc_s;
               end
            end
            ST_AMBER: begin
               if (elapsed_r == AMBER_M1) begin
                  state_r   <= ST_ALLRED;
                  amber_r   <= 4'b0000;
                  elapsed_r <= {CW{1'b0}};
               end else begin
                  elapsed_r <= elapsed_inc_s;
               end
            end
            ST_ALLRED: begin
               if (elapsed_r == ALLRED_M1) begin
                  elapsed_r <= {CW{1'b0}};
                  if (pick_valid_s) begin
                     state_r <= ST_GREEN;
                     grant_r <= onehot4(winner_s);
                     last_r  <= winner_s;
                     gap_r   <= {CW{1'b0}};
                  end else begin
                     state_r <= ST_IDLE;
                  end
               end else begin
                  elapsed_r <= elapsed_inc_s;
               end
            end
            default: begin
               state_r   <= ST_IDLE;
               grant_r   <= 4'b0000;
               amber_r   <= 4'b0000;
               elapsed_r <= {CW{1'b0}};
            end
         endcase
      end
   end

   assign grant   = grant_r;
   assign amber   = amber_r;
   assign state   = state_r;
   assign pending = pending_r;
   assign elapsed = elapsed_r;
   assign last    = last_r;

endmodule

// File: tb/tb_intersection_arbiter.sv
// Scoreboard bench: driver steps an index-based reference model and queues the
// expected outputs; an independent monitor pops and compares after every edge.
module tb_intersection_arbiter;

   localparam int MIN = 10;
   localparam int MAX = 40;
   localparam int GAP = 4;
   localparam int AMB = 6;
   localparam int AR  = 2;
   localparam int CW  = 6;

   typedef struct packed {
      logic [1:0]    st;
      logic [3:0]    gr;
      logic [3:0]    am;
      logic [3:0]    pe;
      logic [CW-1:0] el;
      logic [1:0]    la;
   } obs_t;

   logic          clk;
   logic          reset;
   logic [3:0]    req;
   logic [3:0]    grant;
   logic [3:0]    amber;
   logic [1:0]    state;
   logic [3:0]    pending;
   logic [CW-1:0] elapsed;
   logic [1:0]    last;

   int errors = 0;
   int checks = 0;
   obs_t exp_q[$];

   // Reference model: phase number, served index (-1 = none), counters as ints.
   int       m_phase, m_g, m_a, m_el, m_gap, m_last;
   bit [3:0] m_pend;

   intersection_arbiter #(
      .T_MIN_GREEN(MIN), .T_MAX_GREEN(MAX), .T_GAP(GAP),
      .T_AMBER(AMB), .T_ALLRED(AR), .CW(CW)
   ) dut (
      .clk(clk), .reset(reset), .req(req), .grant(grant), .amber(amber),
      .state(state), .pending(pending), .elapsed(elapsed), .last(last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic obs_t actual();
      obs_t o;
      o = '{st: state, gr: grant, am: amber, pe: pending, el: elapsed, la: last};
      return o;
   endfunction

   function automatic void report(string name, obs_t a, obs_t e);
      $display("FAIL %s: got st=%0d gr=%b am=%b pe=%b el=%0d la=%0d, want st=%0d gr=%b am=%b pe=%b el=%0d la=%0d",
               name, a.st, a.gr, a.am, a.pe, a.el, a.la, e.st, e.gr, e.am, e.pe, e.el, e.la);
   endfunction

   function automatic void model_reset();
      m_phase = 0; m_g = -1; m_a = -1; m_el = 0; m_gap = 0; m_last = 3; m_pend = 4'b0000;
   endfunction

   function automatic int model_pick();
      for (int k = 1; k <= 4; k++) begin
         int d;
         d = (m_last + k) % 4;
         if (m_pend[d]) return d;
      end
      return -1;
   endfunction

   function automatic int imin(int a, int b);
      return (a < b) ? a : b;
   endfunction

   function automatic void model_step(logic [3:0] r);
      int pick, nphase, served;
      bit others;
      pick = model_pick();
      nphase = m_phase;
      served = -1;
      others = 1'b0;
      for (int i = 0; i < 4; i++) if (m_pend[i] && i != m_g) others = 1'b1;
      case (m_phase)
         0: if (pick >= 0) begin nphase = 1; served = pick; end
         1: if (others && m_el >= MIN - 1 && (m_gap >= GAP - 1 || m_el >= MAX - 1)) nphase = 2;
         2: if (m_el == AMB - 1) nphase = 3;
         3: if (m_el == AR - 1) begin
               if (pick >= 0) begin nphase = 1; served = pick; end
               else nphase = 0;
            end
         default: nphase = 0;
      endcase
      for (int i = 0; i < 4; i++) begin
         if (r[i] && !(m_phase == 1 && i == m_g)) m_pend[i] = 1'b1;
         if (i == served) m_pend[i] = 1'b0;
      end
      if (served >= 0) m_gap = 0;
      else if (nphase == 1) m_gap = r[m_g] ? 0 : imin(m_gap + 1, GAP - 1);
      else m_gap = 0;
      if (nphase != m_phase) m_el = 0;
      else m_el = imin(m_el + 1, (nphase == 1) ? MAX - 1 : (1 << CW) - 1);
      if (m_phase == 1 && nphase == 2) m_a = m_g;
      if (served >= 0) begin m_g = served; m_last = served; end
      else if (nphase != 1) m_g = -1;
      m_phase = nphase;
   endfunction

   function automatic obs_t model_obs();
      obs_t o;
      o.st = 2'(m_phase);
      o.gr = (m_phase == 1) ? 4'(1 << m_g) : 4'b0000;
      o.am = (m_phase == 2) ? 4'(1 << m_a) : 4'b0000;
      o.pe = m_pend;
      o.el = CW'(m_el);
      o.la = 2'(m_last);
      return o;
   endfunction

   task automatic drive_step(input logic [3:0] r);
      req = r;
      model_step(r);
      exp_q.push_back(model_obs());
   endtask

   task automatic tick(input logic [3:0] r);
      @(negedge clk);
      drive_step(r);
   endtask

   task automatic check_reset_state(string name);
      obs_t e;
      e = '{st: 2'd0, gr: 4'b0000, am: 4'b0000, pe: 4'b0000, el: '0, la: 2'd3};
      checks++;
      if (actual() !== e) begin errors++; report(name, actual(), e); end
   endtask

   task automatic timeout(string name);
      errors++;
      $display("FAIL %s: wait bound expired, got state=%0d, want phase %0d", name, state, m_phase);
   endtask

   // Monitor: compares each edge against the queued expectation plus invariants.
   int   green_cnt = 0;
   logic [1:0] prev_st = 2'd0;
   always @(posedge clk) begin
      #1;
      if (reset && exp_q.size() > 0) begin
         obs_t e, a;
         e = exp_q.pop_front();
         a = actual();
         checks++;
         if (a !== e) begin errors++; report("cycle", a, e); end
         checks++;
         if ($countones(grant | amber) > 1 || (grant != 4'b0000 && state != 2'd1)) begin
            errors++;
            $display("FAIL lamp_invariant: got st=%0d gr=%b am=%b, want single lamp and green only in GREEN",
                     state, grant, amber);
         end
         if (prev_st == 2'd1 && state == 2'd2) begin
            checks++;
            if (green_cnt < MIN) begin
               errors++;
               $display("FAIL min_green: got %0d green ticks, want at least %0d", green_cnt, MIN);
            end
         end
         green_cnt = (state == 2'd1) ? green_cnt + 1 : 0;
         prev_st = state;
      end else if (!reset) begin
         green_cnt = 0;
         prev_st = 2'd0;
      end
   end

   initial begin
      reset = 1'b0;
      req   = 4'b0000;
      model_reset();
      #12;
      check_reset_state("reset_state");

      // Single request on EW after release; then it rests green.
      @(negedge clk);
      reset = 1'b1;
      drive_step(4'b0000);
      for (int i = 0; i < 3; i++) tick(4'b0000);
      tick(4'b0100);
      for (int i = 0; i < 25; i++) tick(4'b0000);

      // Gap-out: bring NS to green, then NS arrivals every 2 ticks, EW at tick 3.
      tick(4'b0001);
      for (int n = 0; n < 60 && !(m_phase == 1 && m_g == 0); n++) tick(4'b0000);
      if (!(m_phase == 1 && m_g == 0)) timeout("reach_ns_green_gap");
      for (int t = 0; t < 40; t++) begin
         logic [3:0] r;
         r = (t < 12 && t % 2 == 0) ? 4'b0001 : 4'b0000;
         if (t == 3) r = r | 4'b0100;
         tick(r);
      end

      // Max-out: NS held high continuously, SN pulsed once.
      tick(4'b0001);
      for (int n = 0; n < 60 && !(m_phase == 1 && m_g == 0); n++) tick(4'b0001);
      if (!(m_phase == 1 && m_g == 0)) timeout("reach_ns_green_max");
      for (int t = 0; t < 50; t++) tick((t == 1) ? 4'b0011 : 4'b0001);
      for (int i = 0; i < 80; i++) tick(4'b0000);

      // Async reset in the middle of amber.
      tick(4'b1000);
      for (int n = 0; n < 80 && !(m_phase == 2 && m_el == 3); n++) tick(4'b0000);
      if (!(m_phase == 2 && m_el == 3)) timeout("reach_amber");
      @(posedge clk);
      #3;
      reset = 1'b0;
      exp_q.delete();
      model_reset();
      #1;
      check_reset_state("async_reset_amber");
      @(posedge clk);
      #1;
      check_reset_state("reset_held_edge");
      @(negedge clk);
      reset = 1'b1;
      drive_step(4'b0000);

      // Round-robin fairness from IDLE with all four pending.
      tick(4'b1111);
      for (int i = 0; i < 90; i++) tick(4'b0000);

      // SN arrives on the very edge it enters green.
      tick(4'b0011);
      for (int n = 0; n < 120 && m_g != 1; n++) begin
         logic [3:0] r;
         r = (m_phase == 3 && m_el == AR - 1 && model_pick() == 1) ? 4'b0010 : 4'b0000;
         tick(r);
      end
      if (m_g != 1) timeout("reach_sn_green");
      for (int i = 0; i < 15; i++) tick(4'b0000);
      tick(4'b0100);
      for (int i = 0; i < 40; i++) tick(4'b0000);

      // Randomized traffic.
      for (int i = 0; i < 500; i++) begin
         logic [3:0] r;
         for (int b = 0; b < 4; b++) r[b] = ($urandom_range(0, 99) < 12);
         tick(r);
      end

      @(posedge clk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d queued expectations left, want 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/intersection_arbiter.md
Name: intersection_arbiter

Overview:
- Round-robin arbiter that shares the intersection between four approach requesters (NS, SN, EW, WE). Exactly one approach holds green at a time.
- Runs on the 2 Hz tick clock. It takes car-detector pulses and produces one-hot green and amber grants, which drive the lamp encoders and the status message.
- Enforces minimum green, gap-out, maximum green, amber and all-red clearance times, all counted in clock ticks.

Parameters:
- T_MIN_GREEN, 10: minimum green length, ticks (≥2).
- T_MAX_GREEN, 40: maximum green length when another approach is waiting, ticks (> T_MIN_GREEN).
- T_GAP, 4: ticks without an arrival on the green approach before gap-out (≥1).
- T_AMBER, 6: amber length, ticks (≥1).
- T_ALLRED, 2: all-red clearance length, ticks (≥1).
- CW, 6: width of the elapsed and gap counters; must hold T_MAX_GREEN-1.

Ports:
- clk, input, 1: tick clock (2 Hz in the system).
- reset, input, 1: asynchronous, active-low reset.
- req, input, 4: car-detector level per approach (bit0 NS, bit1 SN, bit2 EW, bit3 WE), sampled on clk.
- grant, output, 4: one-hot green for the served approach; 0 when no approach is green.
- amber, output, 4: one-hot amber; nonzero only in AMBER.
- state, output, 2: IDLE=0, GREEN=1, AMBER=2, ALLRED=3.
- pending, output, 4: sticky waiting flags.
- elapsed, output, CW: ticks spent in the current state, starting from 0.
- last, output, 2: index of the most recently granted approach.

Behaviour:
- Reset (asynchronous, while reset=0):
  - state=IDLE, grant=0, amber=0, pending=0, elapsed=0, last=3, so NS wins first. Gap counter is 0.
  - Reset mid-green or mid-amber drops all lamps to red immediately.
- Pending set/clear:
  - pending[i] sets on a clk edge when req[i]=1 and approach i is not currently green.
  - pending[i] clears on the edge that enters GREEN for i. A clear and a set on the same edge resolve to clear (the car is served).
  - req[g] while g is green does not set pending[g]. It resets the gap counter to 0; otherwise the gap counter increments, saturating at T_GAP-1.
- Winner selection:
  - Round-robin over pending, searching from (last+1) mod 4 upward with wrap.
  - Provided by the sub-module rr_pick4.
  - others_pending = |(pending & ~grant).
- elapsed counter:
  - Clears to 0 on every state change.
  - Otherwise increments, saturating at 2^CW-1.
  - In GREEN it saturates at T_MAX_GREEN-1.
- State machine (all transitions on the clk edge):
  - IDLE: if pending≠0 → GREEN. grant=onehot(winner), last=winner, gap=0. Otherwise stay, all red.
  - GREEN:
    - Exit to AMBER when others_pending && elapsed≥T_MIN_GREEN-1 && (gap≥T_GAP-1 || elapsed≥T_MAX_GREEN-1).
    - On exit: amber=grant, grant=0.
    - If no other approach is pending, rest in green indefinitely.
  - AMBER: after T_AMBER ticks (elapsed==T_AMBER-1) → ALLRED, amber=0.
  - ALLRED: after T_ALLRED ticks (elapsed==T_ALLRED-1):
    - → GREEN with a new rr winner if pending≠0.
    - Otherwise → IDLE.
    - The previous approach can win again only if it is the sole pending approach.
- Latency:
  - A req pulse sampled at edge k sets pending at k.
  - From IDLE, grant is asserted after edge k+1.
- Invariants:
  - popcount(grant|amber) ≤ 1.
  - grant≠0 only in GREEN.
  - GREEN never lasts fewer than T_MIN_GREEN ticks.
  - GREEN never lasts more than T_MAX_GREEN ticks while others_pending was continuously high.
- Widths: all comparisons are unsigned on CW bits, and parameters are truncated to CW. Index arithmetic is mod 4, 2 bits, natural wrap.

Decomposition:
- Shared package:
  - State encodings IDLE/GREEN/AMBER/ALLRED.
  - Direction indices DIR_NS=0, DIR_SN=1, DIR_EW=2, DIR_WE=3.
  - Default timing constants, so that the lamp encoder, status message and this block agree.
- One sub-module, rr_pick4:
  - Combinational.
  - Inputs pending[3:0] and last[1:0]; outputs winner[1:0] and valid.
  - Top: FSM, counters and pending register.

Test Plan:
- Reset then single request: reset released, req=0100 for 1 tick at edge 5 → pending=0100 after edge 5; state=GREEN, grant=0100 after edge 6, pending=0; grant rests indefinitely with no other requests.
- Gap-out: NS green, req[NS] pulses every 2 ticks until tick 12, req[EW] pulsed at tick 3 → min green holds until elapsed=9. Gap-out occurs once 4 ticks pass without NS arrivals. Then amber=0001 for 6 ticks, all red for 2 ticks, then grant=0100.
- Max-out: NS green, req[NS] held high continuously, req[SN] pulsed at tick 1 → amber=0001 after exactly 40 green ticks.
- Round-robin fairness: pending=1111 from IDLE with last=3 → grants in order 0001, 0010, 0100, 1000, each after AMBER+ALLRED; pending empties.
- Simultaneous clear/set: req[SN] high on the edge SN enters GREEN → pending[1]=0, and it is not re-served after that green.
- Async reset mid-amber: reset=0 during AMBER elapsed=3 → grant=amber=pending=0 and state=IDLE immediately, without waiting for a clk edge; last=3 after reset is released.
